// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a start bit, shifts a
// command byte with odd parity on device clock edges, then checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] data,
    input  logic       send,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_RELEASE
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       dat_sync_q, dat_sync_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             drv_low_q, drv_low_d;
    logic             done_q, done_d;
    logic             ack_ok_q, ack_ok_d;
    logic             error_q, error_d;

    logic clk_s;
    logic dat_s;
    logic fall;

    // Extra clock stage beyond the 2-FF synchronizer gives the falling-edge reference.
    always_comb begin
        clk_sync_d = {clk_sync_q[1:0], ps2_clk_in};
        dat_sync_d = {dat_sync_q[0], ps2_dat_in};
    end

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];
    assign fall  = clk_sync_q[2] & ~clk_sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
            bit_idx_q  <= '0;
            inh_cnt_q  <= '0;
            to_cnt_q   <= '0;
            drv_low_q  <= 1'b0;
            done_q     <= 1'b0;
            ack_ok_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            bit_idx_q  <= bit_idx_d;
            inh_cnt_q  <= inh_cnt_d;
            to_cnt_q   <= to_cnt_d;
            drv_low_q  <= drv_low_d;
            done_q     <= done_d;
            ack_ok_q   <= ack_ok_d;
            error_q    <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_d     = par_q;
        bit_idx_d = bit_idx_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        drv_low_d = drv_low_q;
        done_d    = 1'b0;
        ack_ok_d  = ack_ok_q;
        error_d   = error_q;

        case (state_q)
            S_IDLE: begin
                if (send) begin
                    shift_d   = data;
                    par_d     = ~^data;
                    ack_ok_d  = 1'b0;
                    error_d   = 1'b0;
                    inh_cnt_d = '0;
                    to_cnt_d  = '0;
                    bit_idx_d = '0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    state_d = S_REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            S_REQ: begin
                state_d   = S_SHIFT;
                to_cnt_d  = '0;
                bit_idx_d = '0;
                drv_low_d = 1'b1;
            end
            S_SHIFT, S_ACK, S_RELEASE: begin
                if (to_cnt_q == TO_LAST) begin
                    state_d  = S_IDLE;
                    error_d  = 1'b1;
                    ack_ok_d = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (state_q == S_SHIFT) begin
                        if (fall) begin
                            // Index 0-7 data LSB first, 8 parity, 9 stop (line released).
                            if (bit_idx_q < 4'd8) begin
                                drv_low_d = ~shift_q[bit_idx_q[2:0]];
                            end else if (bit_idx_q == 4'd8) begin
                                drv_low_d = ~par_q;
                            end else begin
                                drv_low_d = 1'b0;
                                state_d   = S_ACK;
                            end
                            if (bit_idx_q != 4'hF) begin
                                bit_idx_d = bit_idx_q + 1'b1;
                            end
                        end
                    end else if (state_q == S_ACK) begin
                        if (fall) begin
                            ack_ok_d = ~dat_s;
                            state_d  = S_RELEASE;
                        end
                    end else begin
                        if (clk_s && dat_s) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        ps2_clk_oe = (state_q == S_INHIBIT) || (state_q == S_REQ);
        ps2_dat_oe = (state_q == S_REQ) || ((state_q == S_SHIFT) && drv_low_q);
        done       = done_q;
        ack_ok     = ack_ok_q;
        error      = error_q;
    end

endmodule
